cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It generalises the fixed 32-bit two-block CLA to any `WIDTH` that is a multiple of `BLOCK`. One register stage per `BLOCK`-wide lookahead group, so the clock period is bounded by a single group's carry logic. It adds a subtract mode, signed-overflow detection and a valid/ready handshake with back-pressure, and serves as the arithmetic unit between operand-fetch and writeback stages.

## Interface
- `WIDTH`, 32: operand/result width; must be a multiple of `BLOCK`.
- `BLOCK`, 16: bits per lookahead group and per pipeline stage; `NBLK = WIDTH/BLOCK` stages.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block can accept this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in (add) / borrow-in (sub).
- `sub`  in  1  0: add, 1: subtract.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry-out of MSB (for sub: 1 = no borrow).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- Add: `{cout,sum} = a + b + cin`.
- Sub: `{cout,sum} = a + ~b + ~cin`, i.e. `a - b - cin`; `cout` is the raw carry (0 means borrow).
- `ovf` = carry into MSB XOR carry out of MSB, taken from the effective operands (`b` inverted when `sub`=1).
- Stage k (0..NBLK-1) computes group k, bits [k*BLOCK +: BLOCK], from group-local generate/propagate and the registered carry of stage k-1; stage 0 uses the effective carry-in.
- Upper operand groups are skewed through delay registers; completed lower sum groups are carried forward through delay registers, so all groups of one transaction exit together.
- Each stage holds a valid bit; the pipeline is a single lock-step shift register. No bubble compression.
- Global advance: `en = ~out_valid | out_ready`; `in_ready = en`. When `en`=0, all stage registers and valid bits hold.
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`. Results leave strictly in acceptance order.

## Timing
- Latency: a transfer accepted at edge t appears with `out_valid`=1 after edge t+NBLK-1 (NBLK cycles; 2 for defaults), provided no stall.
- Throughput: one transaction per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid` (registered) and `out_ready`. There is no combinational path from `in_valid`, `a` or `b` to any output.
- When `en`=1 and `in_valid`=0, a bubble (valid 0) enters stage 0.
- When `out_valid`=1 and `out_ready`=0: everything holds, `in_ready`=0, and `sum`/`cout`/`ovf` stay stable until accepted.
- Reset (`rst`=1 at an edge): all valid bits become 0, and `sum`, `cout`, `ovf` and all pipeline data registers become 0. `out_valid`=0 and `in_ready`=1 from the next cycle.
- Reset mid-operation discards in-flight transactions. Inputs during `rst`=1 are ignored.
- `rst` has priority over `en`.
- `NBLK`=1 degenerates to a single registered stage with latency 1.

## Test plan
Defaults: WIDTH=32, BLOCK=16. Each case checks latency 2.
- Cross-group carry: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00010000, cout=0, ovf=0.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Same operands with cin=1 -> sum=0x00000001, cout=1.
- Signed overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=1, sub=1, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=5, b=3, sub=1, cin=1 -> sum=1, cout=1.
- Back-pressure: stream 6 random ops back-to-back, drive `out_ready`=0 for 3 cycles mid-stream. Expect `in_ready`=0 exactly while `out_valid`&~`out_ready`, outputs held stable, and all 6 results correct, in order, none duplicated. Random scoreboard of ≥10k ops against a reference model with random `in_valid`/`out_ready`.
- Reset mid-flight: accept 2 ops, assert `rst` for 1 cycle. Expect `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0 next cycle, no stale result ever emitted, and a new op returns correctly 2 cycles after acceptance.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead group per
// register stage, lock-step valid pipeline with a single global advance enable.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  // WIDTH must be a whole multiple of BLOCK.
  localparam int NBLK = WIDTH / BLOCK;

  // Handshake: a stage register moves only when en=1; the output is offered while
  // out_valid=1 and held until out_ready=1, and in_ready mirrors en so a new operand
  // set is taken exactly when the whole pipeline shifts.
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_q;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c_eff = cin ^ sub;

  function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;
    localparam int UW = WIDTH - HI;

    logic [BLOCK-1:0] x;
    logic [BLOCK-1:0] y;
    logic             ci;
    logic             vi;
    logic [BLOCK:0]   grp;
    logic [HI-1:0]    sum_d;
    logic [HI-1:0]    sum_q;
    logic             c_q;
    logic             v_q;

    assign grp = cla_group(x, y, ci);

    if (k == 0) begin : g_head
      assign x     = a[BLOCK-1:0];
      assign y     = b_eff[BLOCK-1:0];
      assign ci    = c_eff;
      assign vi    = in_valid;
      assign sum_d = grp[BLOCK-1:0];
    end else begin : g_body
      assign x     = g_stg[k-1].g_up.a_q[BLOCK-1:0];
      assign y     = g_stg[k-1].g_up.b_q[BLOCK-1:0];
      assign ci    = g_stg[k-1].c_q;
      assign vi    = g_stg[k-1].v_q;
      assign sum_d = {grp[BLOCK-1:0], g_stg[k-1].sum_q};
    end

    // Operand bits of groups not yet summed ride along, skewed one stage per group.
    if (UW > 0) begin : g_up
      logic [UW-1:0] a_d;
      logic [UW-1:0] b_d;
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = a[WIDTH-1:HI];
        assign b_d = b_eff[WIDTH-1:HI];
      end else begin : g_src_prev
        assign a_d = g_stg[k-1].g_up.a_q[WIDTH-LO-1:BLOCK];
        assign b_d = g_stg[k-1].g_up.b_q[WIDTH-LO-1:BLOCK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        c_q   <= grp[BLOCK];
        v_q   <= vi;
      end
    end
  end

  // Carry into the MSB equals x^y^s at the MSB, so overflow needs no extra carry tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= g_stg[NBLK-1].x[BLOCK-1] ^ g_stg[NBLK-1].y[BLOCK-1] ^
               g_stg[NBLK-1].grp[BLOCK-1] ^ g_stg[NBLK-1].grp[BLOCK];
    end
  end

  assign out_valid = g_stg[NBLK-1].v_q;
  assign sum       = g_stg[NBLK-1].sum_q;
  assign cout      = g_stg[NBLK-1].c_q;
  assign ovf       = ovf_q;
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: arithmetic reference model with an expected-result
// queue, per-cycle handshake/hold checks, and directed literal vectors.
module tb_cla_pipe_adder;
  localparam int W    = 32;
  localparam int NBLK = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int           total = 0;
  int           bad = 0;
  int           n_pop = 0;
  int           n_stall = 0;
  bit           done = 1'b0;
  logic [W+1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  cla_pipe_adder #(.WIDTH(W), .BLOCK(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result = {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    longint u;
    longint t;
    logic   c;
    logic   o;
    if (!s) begin
      u = longint'(x) + longint'(y) + longint'(ci);
      t = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      c = (u > 64'sd4294967295);
    end else begin
      u = longint'(x) - longint'(y) - longint'(ci);
      t = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
      c = (u >= 0);
    end
    o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return {c, o, u[W-1:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", sum, prev_sum);
        chk("hold_cout", cout, prev_cout);
        chk("hold_ovf", ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum=%0h expected none", sum);
        end else begin
          e = exp_q.pop_front();
          chk("res_sum", sum, e[W-1:0]);
          chk("res_cout", cout, e[W+1]);
          chk("res_ovf", ovf, e[W]);
          n_pop++;
        end
      end
      if (out_valid && !out_ready) n_stall++;
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int n;
    n        = 0;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    chk({nm, "_model"}, model(x, y, ci, s), {ec, eo, es});
    out_ready = 1'b1;
    send(x, y, ci, s);
    chk({nm, "_early"}, out_valid, 1'b0);
    repeat (NBLK - 1) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int s0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    directed("xgrp",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    directed("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("wrapc", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
    directed("ovfa",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovfs",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("borr",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("subc",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    directed("sube",  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // back-pressure: 6 ops back-to-back, consumer stalls 3 cycles mid-stream
    p0 = n_pop;
    s0 = n_stall;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", n_pop - p0, 6);
    chk("bp_stalls", n_stall - s0, 3);

    // reset mid-flight: two ops held in the pipe, then a one-cycle reset
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    chk("rf_loaded", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rf_out_valid", out_valid, 1'b0);
    chk("rf_sum", sum, 32'h0);
    chk("rf_cout", cout, 1'b0);
    chk("rf_ovf", ovf, 1'b0);
    chk("rf_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("rf_no_stale", out_valid, 1'b0);
    end
    directed("rfnew", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

    // random traffic against the reference queue
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
              @(posedge clk);
              #1;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rnd");
    chk("rnd_count", n_pop - p0, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
